// File: rtl/matrix_scan.sv
// ============================================================================
// Module  : matrix_scan
// Brief   : HUB75 64x32 1/16-scan controller with binary-coded modulation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_scan #(
  parameter int FETCH_WAIT = 4,
  parameter int BASE_TICKS = 8,
  parameter int PLANES     = 5
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] rgb565_top,
  input  logic [15:0] rgb565_bottom,
  output logic [5:0]  column_address,
  output logic [3:0]  row_address,
  output logic        pixel_load_start,
  output logic [2:0]  rgb1,
  output logic [2:0]  rgb2,
  output logic        hub75_clk,
  output logic        hub75_latch,
  output logic        hub75_oe_n,
  output logic [3:0]  row_select,
  output logic        frame_start
);

  localparam int c_PLANE_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int c_FCNT_W    = (FETCH_WAIT > 0) ? $clog2(FETCH_WAIT + 1) : 1;
  localparam int c_MAX_TICKS = BASE_TICKS << (PLANES - 1);
  localparam int c_TIMER_W   = $clog2(c_MAX_TICKS + 1);

  localparam logic [2:0] c_FETCH     = 3'd0;
  localparam logic [2:0] c_SHIFT_LO  = 3'd1;
  localparam logic [2:0] c_SHIFT_HI  = 3'd2;
  localparam logic [2:0] c_WAIT_DISP = 3'd3;
  localparam logic [2:0] c_BLANK     = 3'd4;
  localparam logic [2:0] c_LATCH     = 3'd5;
  localparam logic [2:0] c_UNBLANK   = 3'd6;

  localparam logic [c_FCNT_W-1:0]  c_FETCH_LAST = c_FCNT_W'(FETCH_WAIT);
  localparam logic [c_PLANE_W-1:0] c_PLANE_LAST = c_PLANE_W'(PLANES - 1);
  localparam logic [c_TIMER_W-1:0] c_BASE       = c_TIMER_W'(BASE_TICKS);

  logic [2:0]           r_state;
  logic [c_FCNT_W-1:0]  r_fcnt;
  logic [5:0]           r_col;
  logic [3:0]           r_row;
  logic [c_PLANE_W-1:0] r_plane;
  logic [c_TIMER_W-1:0] r_timer;
  logic [2:0]           r_rgb1;
  logic [2:0]           r_rgb2;
  logic [3:0]           r_row_sel;

  logic [3:0] w_pidx;
  logic [2:0] w_top_bits;
  logic [2:0] w_bot_bits;
  logic       w_last_plane;
  logic       w_unused;

  // Green LSB (bit 5) never reaches the panel: green is reduced to 5 bits.
  assign w_pidx       = 4'(r_plane);
  assign w_top_bits   = {rgb565_top[w_pidx], rgb565_top[4'd6 + w_pidx], rgb565_top[4'd11 + w_pidx]};
  assign w_bot_bits   = {rgb565_bottom[w_pidx], rgb565_bottom[4'd6 + w_pidx],
                         rgb565_bottom[4'd11 + w_pidx]};
  assign w_last_plane = (r_plane == c_PLANE_LAST);
  assign w_unused     = rgb565_top[5] ^ rgb565_bottom[5];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state   <= c_FETCH;
      r_fcnt    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_plane   <= '0;
      r_timer   <= '0;
      r_rgb1    <= '0;
      r_rgb2    <= '0;
      r_row_sel <= '0;
    end else begin
      // Display timer runs independently so display of one plane overlaps shifting of the next.
      if (r_state == c_UNBLANK) begin
        r_timer <= c_BASE << r_plane;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end

      case (r_state)
        c_FETCH: begin
          if (r_fcnt == c_FETCH_LAST) begin
            r_fcnt  <= '0;
            r_rgb1  <= w_top_bits;
            r_rgb2  <= w_bot_bits;
            r_state <= c_SHIFT_LO;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        c_SHIFT_LO: r_state <= c_SHIFT_HI;
        c_SHIFT_HI: begin
          if (r_col == 6'd63) begin
            r_state <= c_WAIT_DISP;
          end else begin
            r_col   <= r_col + 1'b1;
            r_state <= c_FETCH;
          end
        end
        c_WAIT_DISP: begin
          if (r_timer == '0) begin
            r_state <= c_BLANK;
          end
        end
        c_BLANK: r_state <= c_LATCH;
        c_LATCH: begin
          r_row_sel <= r_row;
          r_state   <= c_UNBLANK;
        end
        c_UNBLANK: begin
          if (w_last_plane) begin
            r_plane <= '0;
            r_row   <= r_row + 1'b1;
          end else begin
            r_plane <= r_plane + 1'b1;
          end
          r_col   <= '0;
          r_state <= c_FETCH;
        end
        default: r_state <= c_FETCH;
      endcase
    end
  end

  // Gated by reset so the request stays low while held in reset yet fires in the first cycle after.
  assign pixel_load_start = (r_state == c_FETCH) && (r_fcnt == '0) && !reset;
  assign column_address   = r_col;
  assign row_address      = r_row;
  assign rgb1             = r_rgb1;
  assign rgb2             = r_rgb2;
  assign hub75_clk        = (r_state == c_SHIFT_HI);
  assign hub75_latch      = (r_state == c_LATCH);
  assign hub75_oe_n       = (r_timer == '0);
  assign row_select       = r_row_sel;
  assign frame_start      = (r_state == c_UNBLANK) && (r_row == 4'd15) && w_last_plane;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan.sv
// ============================================================================
// Module  : tb_matrix_scan
// Brief   : Directed self-checking bench for matrix_scan with an RGB scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_matrix_scan;

  localparam int FW   = 4;
  localparam int BASE = 8;
  localparam int NPL  = 5;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [15:0] rgb565_top;
  logic [15:0] rgb565_bottom;
  logic [5:0]  column_address;
  logic [3:0]  row_address;
  logic        pixel_load_start;
  logic [2:0]  rgb1;
  logic [2:0]  rgb2;
  logic        hub75_clk;
  logic        hub75_latch;
  logic        hub75_oe_n;
  logic [3:0]  row_select;
  logic        frame_start;

  matrix_scan #(.FETCH_WAIT(FW), .BASE_TICKS(BASE), .PLANES(NPL)) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .rgb565_top      (rgb565_top),
    .rgb565_bottom   (rgb565_bottom),
    .column_address  (column_address),
    .row_address     (row_address),
    .pixel_load_start(pixel_load_start),
    .rgb1            (rgb1),
    .rgb2            (rgb2),
    .hub75_clk       (hub75_clk),
    .hub75_latch     (hub75_latch),
    .hub75_oe_n      (hub75_oe_n),
    .row_select      (row_select),
    .frame_start     (frame_start)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  logic [5:0] sb[$];
  int cyc, last_pls, exp_col, exp_row, exp_plane;
  int pass_row, pass_plane, lat_row, lat_plane;
  int clk_rises, latches, oe_w, widths_seen, frames;
  logic prev_clk, prev_latch, prev_oe;
  logic [3:0] prev_rs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] bits(input logic [15:0] w, input int p);
    return {w[p], w[6+p], w[11+p]};
  endfunction

  task automatic model_reset();
    sb.delete();
    cyc = 0; last_pls = 0; exp_col = 0; exp_row = 0; exp_plane = 0;
    pass_row = 0; pass_plane = 0; lat_row = 0; lat_plane = 0;
    clk_rises = 0; latches = 0; oe_w = 0; widths_seen = 0; frames = 0;
    prev_clk = 1'b0; prev_latch = 1'b0; prev_oe = 1'b1; prev_rs = 4'd0;
  endtask

  // Called once per cycle, shortly after the falling edge.
  task automatic observe();
    logic [15:0] t, b;
    logic [5:0]  e;
    cyc++;
    if (pixel_load_start) begin
      chk("pls_col", 32'(column_address), 32'(exp_col));
      chk("pls_row", 32'(row_address), 32'(exp_row));
      if (exp_col != 0) chk("pls_gap", 32'(cyc - last_pls), 32'(FW + 3));
      last_pls = cyc;
      if (exp_col == 0) begin
        pass_row   = exp_row;
        pass_plane = exp_plane;
      end
      case (exp_row)
        0:       begin t = 16'hFFFF; b = 16'h0000; end
        1:       begin t = 16'hF800; b = 16'h001F; end
        2:       begin t = 16'h0020; b = 16'h07E0; end
        default: begin t = 16'($urandom); b = 16'($urandom); end
      endcase
      rgb565_top    = t;
      rgb565_bottom = b;
      sb.push_back({bits(t, exp_plane), bits(b, exp_plane)});
      exp_col++;
      if (exp_col == 64) begin
        exp_col = 0;
        exp_plane++;
        if (exp_plane == NPL) begin
          exp_plane = 0;
          exp_row   = (exp_row + 1) % 16;
        end
      end
    end
    if (hub75_clk && !prev_clk) begin
      clk_rises++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rgb_shift", 32'({rgb1, rgb2}), 32'(e));
      end
    end
    if (hub75_latch) begin
      chk("latch_clk_edges", 32'(clk_rises), 32'd64);
      chk("latch_oe_clk", 32'({hub75_oe_n, hub75_clk}), 32'b10);
      clk_rises = 0;
      latches++;
      lat_row   = pass_row;
      lat_plane = pass_plane;
    end
    if (prev_latch) chk("row_select_val", 32'(row_select), 32'(lat_row));
    if (row_select != prev_rs) chk("row_select_when", 32'(prev_latch), 32'd1);
    if (!hub75_oe_n) begin
      oe_w++;
    end else if (!prev_oe) begin
      chk("oe_width", 32'(oe_w), 32'(BASE << lat_plane));
      oe_w = 0;
      widths_seen++;
    end
    if (frame_start) begin
      chk("frame_latches", 32'(latches), 32'd80);
      chk("frame_pos", 32'(pass_row * 8 + pass_plane), 32'(15 * 8 + NPL - 1));
      latches = 0;
      frames++;
    end
    prev_clk   = hub75_clk;
    prev_latch = hub75_latch;
    prev_oe    = hub75_oe_n;
    prev_rs    = row_select;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"}, 32'(column_address), 32'd0);
    chk({tag, "_row"}, 32'(row_address), 32'd0);
    chk({tag, "_pls"}, 32'(pixel_load_start), 32'd0);
    chk({tag, "_rgb"}, 32'({rgb1, rgb2}), 32'd0);
    chk({tag, "_clk_latch"}, 32'({hub75_clk, hub75_latch}), 32'd0);
    chk({tag, "_oe_n"}, 32'(hub75_oe_n), 32'd1);
    chk({tag, "_rs_fs"}, 32'({row_select, frame_start}), 32'd0);
  endtask

  initial begin
    int guard;
    logic found;
    reset = 1'b1;
    rgb565_top = '0;
    rgb565_bottom = '0;
    model_reset();
    repeat (3) @(negedge clk_in);
    #1;
    chk_reset_outputs("reset");

    @(negedge clk_in);
    reset = 1'b0;
    #1;
    chk("first_pls", 32'(pixel_load_start), 32'd1);
    observe();

    // One full frame plus a few passes of the next one.
    guard = 0;
    while (!(frames >= 1 && latches >= 5) && guard < 45000) begin
      @(negedge clk_in);
      #1;
      observe();
      guard++;
    end
    chk("frame_seen", 32'(frames), 32'd1);
    chk("oe_pulses_seen", 32'(widths_seen >= 80), 32'd1);

    // Reset during SHIFT_HI while the panel is lit.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_in);
      #1;
      if (hub75_clk && !hub75_oe_n) found = 1'b1;
    end
    chk("midrst_found", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_oe_n", 32'(hub75_oe_n), 32'd1);
    chk("midrst_clk", 32'(hub75_clk), 32'd0);
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk_in);
    model_reset();
    reset = 1'b0;
    #1;
    chk("restart_pls", 32'(pixel_load_start), 32'd1);
    observe();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      #1;
      observe();
    end
    chk("restart_progress", 32'(exp_col), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_scan.md
# matrix_scan

Scan controller that sits downstream of the framebuffer fetch stage and drives a 64×32 HUB75 panel (1/16 scan) with binary-coded modulation (BCM). It sequences column and row addresses plus `pixel_load_start` into the fetch stage, then samples the returned `rgb565_top`/`rgb565_bottom` words. It serialises one bitplane per pass into the panel shift registers and generates the clock, latch, output-enable and row-select signals. Each plane's display time overlaps the shifting of the next plane.

## Interface
- `FETCH_WAIT`, default 4: clk_in cycles from the `pixel_load_start` pulse until both RGB565 words are valid.
- `BASE_TICKS`, default 8: display time of plane 0 in clk_in cycles. Plane p displays `BASE_TICKS << p` cycles. Must be ≥1.
- `PLANES`, default 5: number of bitplanes.

Ports:
- `clk_in` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `rgb565_top` in 16: pixel for the top half, from the fetch stage.
- `rgb565_bottom` in 16: pixel for the bottom half, from the fetch stage.
- `column_address` out 6: column to fetch.
- `row_address` out 4: row to fetch.
- `pixel_load_start` out 1: one-cycle fetch request.
- `rgb1` out 3: top-half bit, ordered {B,G,R}.
- `rgb2` out 3: bottom-half bit, ordered {B,G,R}.
- `hub75_clk` out 1: panel shift clock.
- `hub75_latch` out 1: panel latch.
- `hub75_oe_n` out 1: panel output enable, active-low.
- `row_select` out 4: panel A–D row lines, giving the displayed row.
- `frame_start` out 1: one-cycle pulse at the start of each frame.

## Operation
- Scan order:
  - Outer loop: row 0..15. Middle loop: plane 0..PLANES-1. Inner loop: column 0..63.
  - `row_address` and `column_address` carry the position currently being shifted.
- Bit extraction for plane p:
  - R = word[11+p]
  - G = word[6+p] (the green LSB is dropped)
  - B = word[p]
- States:
  - FETCH: assert `pixel_load_start` for exactly one cycle, then count `FETCH_WAIT` cycles. On the last count, register the `rgb1`/`rgb2` bits and go to SHIFT_LO.
  - SHIFT_LO: `hub75_clk`=0 with data stable. Go to SHIFT_HI.
  - SHIFT_HI: `hub75_clk`=1.
    - Column <63: increment the column and go to FETCH.
    - Column 63: go to WAIT_DISP.
  - WAIT_DISP: hold until the display timer reaches 0, then go to BLANK.
  - BLANK: `hub75_oe_n`=1 for 1 cycle. Go to LATCH.
  - LATCH: `hub75_latch`=1 for 1 cycle. `row_select` ← shifted row. Go to UNBLANK.
  - UNBLANK:
    - Load the display timer with `BASE_TICKS << plane` and drive `hub75_oe_n`=0.
    - Advance the plane; on the last plane, set the plane to 0 and advance the row.
    - Reset the column to 0 and go to FETCH.
- Display timer: an independent down-counter. It decrements every cycle while nonzero. `hub75_oe_n`=0 while the timer is nonzero, otherwise 1. It is wide enough for `BASE_TICKS << (PLANES-1)`.
- Wrap-around: row 15 with the last plane wraps to row 0, plane 0, and pulses `frame_start` in the UNBLANK cycle.
- If the timer is already 0 on entry to WAIT_DISP, WAIT_DISP lasts 1 cycle.

## Timing
- Reset values: every output is 0, except `hub75_oe_n`=1.
  - Internal column, row, plane and timer are 0; the state is FETCH.
  - Reset mid-operation blanks the panel immediately, without waiting for an edge.
- After reset deasserts, the first `pixel_load_start` is asserted in the first clk_in cycle.
- Per pixel: `FETCH_WAIT`+3 cycles (1 pulse + FETCH_WAIT + SHIFT_LO + SHIFT_HI).
- `rgb1`/`rgb2` change only on entry to SHIFT_LO, so they are stable for a full cycle before each `hub75_clk` rising edge.
- `hub75_latch` is asserted only while `hub75_oe_n`=1 and `hub75_clk`=0.
- `row_select` changes only in the LATCH cycle.
- `pixel_load_start` is never re-asserted within `FETCH_WAIT` cycles of the previous pulse.

## Test plan
- Reset then release:
  - Cycle 1: `pixel_load_start`=1 with col=0 and row=0.
  - It pulses every 7 cycles.
  - Exactly 64 `hub75_clk` rising edges occur before the first `hub75_latch`.
- Top word 0xFFFF, bottom word 0x0000 on plane 0: every shifted `rgb1`=3'b111 and `rgb2`=3'b000.
- Word 0xF800 (pure red): `rgb1`=3'b001 for planes 0–4.
- Word 0x0020 (green LSB only): `rgb1`=3'b000 for all planes.
- `BASE_TICKS`=8:
  - `hub75_oe_n` low-pulse widths measure 8, 16, 32, 64, 128 cycles for planes 0–4.
  - BLANK/LATCH follow each pulse; `row_select` updates only at the latch.
- Frame wrap:
  - `frame_start` pulses once per 80 latches, with `row_select`=0 following row 15.
  - Asserting `reset` mid-SHIFT_HI drives `hub75_oe_n`=1 and `hub75_clk`=0 within the same cycle, and the scan restarts at col=0, row=0.
